// File: rtl/noc_pkg.sv
// Shared flit-type encodings, arbiter state type and flit-type accessor for the NoC port arbiter.
package noc_pkg;

  localparam int unsigned NOC_FW  = 36;
  localparam int unsigned NOC_FTW = 3;

  localparam logic [NOC_FTW-1:0] FT_HEAD   = 3'd1;
  localparam logic [NOC_FTW-1:0] FT_BODY   = 3'd2;
  localparam logic [NOC_FTW-1:0] FT_TAIL   = 3'd3;
  localparam logic [NOC_FTW-1:0] FT_SINGLE = 3'd4;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic logic [NOC_FTW-1:0] flit_type(input logic [NOC_FW-1:0] flit);
    return flit[NOC_FW-1 -: NOC_FTW];
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin priority select: first requester at or after ptr, wrapping.
module rr_arb #(
  parameter int unsigned N  = 6,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = PW'((32'(ptr) + 32'(i)) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arb.sv
// Credit-based round-robin arbiter sharing one output link among NREQ requesters.
// Define NOC_ARB_WORMHOLE_EN to lock the link to one requester from HEAD to TAIL.
module noc_port_arb
  import noc_pkg::*;
#(
  parameter int unsigned FW   = NOC_FW,
  parameter int unsigned FTW  = NOC_FTW,
  parameter int unsigned NREQ = 6,
  parameter int unsigned B    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FW*NREQ-1:0]       req_flit,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  output logic [FW-1:0]            flit_out,
  output logic                     flit_out_wr,
  input  logic                     credit_in,
  output logic [$clog2(B+1)-1:0]   credit_cnt,
  output logic                     err_credit
);

  localparam int unsigned CW = $clog2(B+1);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] lock_mask;
  logic            grant;
  logic            ptr_adv;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   ptr_q;
  logic [FW-1:0]   sel_flit;

  assign eligible  = (rst_n && credit_cnt != '0) ? (req_valid & lock_mask) : '0;
  assign grant     = |gnt;
  assign req_ready = gnt;

  rr_arb #(.N(NREQ), .PW(PW)) u_rr_arb (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (gnt[r]) gidx = PW'(r);
    end
  end

  assign sel_flit = req_flit[FW*gidx +: FW];

`ifdef NOC_ARB_WORMHOLE_EN
  arb_state_t     state_q, state_next;
  logic [PW-1:0]  owner_q, owner_next;
  logic [FTW-1:0] ftype;

  assign ftype     = FTW'(flit_type(NOC_FW'(sel_flit)));
  assign lock_mask = (state_q == ARB_LOCKED) ? (NREQ'(1) << owner_q) : '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_next;
      owner_q <= owner_next;
    end
  end

  // Lock on HEAD, release on the owner's TAIL; pointer moves only at packet end.
  always_comb begin
    state_next = state_q;
    owner_next = owner_q;
    ptr_adv    = 1'b0;
    if (grant) begin
      ptr_adv = (ftype == FT_TAIL) || (ftype == FT_SINGLE);
      case (state_q)
        ARB_IDLE: begin
          if (ftype == FT_HEAD) begin
            state_next = ARB_LOCKED;
            owner_next = gidx;
          end
        end
        ARB_LOCKED: begin
          if (ftype == FT_TAIL) state_next = ARB_IDLE;
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end
`else
  assign lock_mask = '1;
  assign ptr_adv   = grant;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ptr_adv) begin
      ptr_q <= (gidx == PW'(NREQ-1)) ? '0 : PW'(gidx + PW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_out    <= '0;
      flit_out_wr <= 1'b0;
    end else begin
      flit_out_wr <= grant;
      if (grant) flit_out <= sel_flit;
    end
  end

  // A returned credit with the counter already full is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_cnt <= CW'(B);
      err_credit <= 1'b0;
    end else if (grant && !credit_in) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (!grant && credit_in) begin
      if (credit_cnt == CW'(B)) err_credit <= 1'b1;
      else                      credit_cnt <= credit_cnt + CW'(1);
    end
  end

endmodule
